// File: rtl/alu_4bit.sv
// 4-bit ALU: eight adder-based ops and four bitwise ops, with result and
// C/V/Z/N flags captured in registers one cycle after the inputs.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       G_select,
  output logic [WIDTH-1:0] G,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N
);

  logic             is_logic;
  logic [1:0]       op_sel;
  logic             cin;
  logic [WIDTH-1:0] y_operand;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_low;
  logic             carry_into_msb;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] not_v;

  logic [WIDTH-1:0] g_d, g_q;
  logic             c_d, c_q;
  logic             v_d, v_q;
  logic             z_d, z_q;
  logic             n_d, n_q;

  assign is_logic = G_select[3];
  assign op_sel   = G_select[2:1];
  assign cin      = G_select[0];

  // B-operand conditioning for the adder path.
  always_comb begin
    y_operand = '0;
    case (op_sel)
      2'b00:   y_operand = '0;
      2'b01:   y_operand = B;
      2'b10:   y_operand = ~B;
      default: y_operand = '1;
    endcase
  end

  assign sum_full = {1'b0, A} + {1'b0, y_operand} + (WIDTH+1)'(cin);

  // Sum of the lower bits alone; its top bit is the carry into the MSB,
  // which together with the carry out gives two's-complement overflow.
  assign sum_low = {1'b0, A[WIDTH-2:0]} + {1'b0, y_operand[WIDTH-2:0]} + WIDTH'(cin);
  assign carry_into_msb = sum_low[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_v[gi] = A[gi] & B[gi];
      assign or_v[gi]  = A[gi] | B[gi];
      assign xor_v[gi] = A[gi] ^ B[gi];
      assign not_v[gi] = ~A[gi];
    end
  endgenerate

  always_comb begin
    g_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    if (is_logic) begin
      case (op_sel)
        2'b00:   g_d = and_v;
        2'b01:   g_d = or_v;
        2'b10:   g_d = xor_v;
        default: g_d = not_v;
      endcase
    end else begin
      g_d = sum_full[WIDTH-1:0];
      c_d = sum_full[WIDTH];
      v_d = carry_into_msb ^ sum_full[WIDTH];
    end
    z_d = (g_d == '0);
    n_d = g_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b1;
      n_q <= 1'b0;
    end else begin
      g_q <= g_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign G = g_q;
  assign C = c_q;
  assign V = v_q;
  assign Z = z_q;
  assign N = n_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed-vector bench for alu_4bit: table of hand-computed results plus
// reset, mid-stream reset and hold-between-edges sequences.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] G_select;
  logic [3:0] G;
  logic       C;
  logic       V;
  logic       Z;
  logic       N;

  int n_compared;
  int n_mismatched;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [3:0] g;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[$];

  alu_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .G_select (G_select),
    .G        (G),
    .C        (C),
    .V        (V),
    .Z        (Z),
    .N        (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(string name, logic [3:0] a, logic [3:0] b, logic [3:0] sel,
                              logic [3:0] g, logic c, logic v, logic z, logic n);
    vec_t r;
    r.name = name; r.a = a; r.b = b; r.sel = sel;
    r.g = g; r.c = c; r.v = v; r.z = z; r.n = n;
    return r;
  endfunction

  task automatic check(string name, logic [3:0] eg, logic ec, logic ev, logic ez, logic en);
    n_compared++;
    if ({G, C, V, Z, N} !== {eg, ec, ev, ez, en}) begin
      n_mismatched++;
      $display("FAIL %s: got G=%b C=%b V=%b Z=%b N=%b, expected G=%b C=%b V=%b Z=%b N=%b",
               name, G, C, V, Z, N, eg, ec, ev, ez, en);
    end else begin
      $display("ok   %s: G=%b C=%b V=%b Z=%b N=%b", name, G, C, V, Z, N);
    end
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic apply(logic r, logic [3:0] a, logic [3:0] b, logic [3:0] sel);
    rst = r; A = a; B = b; G_select = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1; A = 4'b1010; B = 4'b0110; G_select = 4'b0011;

    vecs.push_back(mk("add_3p12",      4'b0011, 4'b1100, 4'b0010, 4'b1111, 0, 0, 0, 1));
    vecs.push_back(mk("addc_3p12",     4'b0011, 4'b1100, 4'b0011, 4'b0000, 1, 0, 1, 0));
    vecs.push_back(mk("addnb_3_12",    4'b0011, 4'b1100, 4'b0100, 4'b0110, 0, 0, 0, 0));
    vecs.push_back(mk("sub_3m12",      4'b0011, 4'b1100, 4'b0101, 4'b0111, 0, 0, 0, 0));
    vecs.push_back(mk("and_3_12",      4'b0011, 4'b1100, 4'b1000, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk("or_3_12",       4'b0011, 4'b1100, 4'b1010, 4'b1111, 0, 0, 0, 1));
    vecs.push_back(mk("xor_3_12",      4'b0011, 4'b1100, 4'b1100, 4'b1111, 0, 0, 0, 1));
    vecs.push_back(mk("not_3",         4'b0011, 4'b1100, 4'b1110, 4'b1100, 0, 0, 0, 1));
    vecs.push_back(mk("and_sel0_ign",  4'b0011, 4'b1100, 4'b1001, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk("add_ovf",       4'b0111, 4'b0001, 4'b0010, 4'b1000, 0, 1, 0, 1));
    vecs.push_back(mk("sub_ovf",       4'b1000, 4'b0001, 4'b0101, 4'b0111, 1, 1, 0, 0));
    vecs.push_back(mk("dec_zero",      4'b0000, 4'b0000, 4'b0110, 4'b1111, 0, 0, 0, 1));
    vecs.push_back(mk("inc_wrap",      4'b1111, 4'b0000, 4'b0001, 4'b0000, 1, 0, 1, 0));
    vecs.push_back(mk("pass_a",        4'b0101, 4'b1010, 4'b0000, 4'b0101, 0, 0, 0, 0));
    vecs.push_back(mk("pass_a_c1",     4'b0101, 4'b1010, 4'b0111, 4'b0101, 1, 0, 0, 0));
    vecs.push_back(mk("inc_ovf",       4'b0111, 4'b0000, 4'b0001, 4'b1000, 0, 1, 0, 1));
    vecs.push_back(mk("addnb_ovf",     4'b1000, 4'b0000, 4'b0100, 4'b0111, 1, 1, 0, 0));
    vecs.push_back(mk("dec_ovf",       4'b1000, 4'b1111, 4'b0110, 4'b0111, 1, 1, 0, 0));
    vecs.push_back(mk("or_sel0_ign",   4'b0101, 4'b1010, 4'b1011, 4'b1111, 0, 0, 0, 1));
    vecs.push_back(mk("xor_same",      4'b0101, 4'b0101, 4'b1101, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk("not_zero",      4'b0000, 4'b1111, 4'b1111, 4'b1111, 0, 0, 0, 1));

    // Reset held for two edges with arbitrary inputs.
    @(posedge clk); #1;
    check("reset_edge1", 4'b0000, 0, 0, 1, 0);
    apply(1'b1, 4'b1111, 4'b1111, 4'b0010);
    check("reset_edge2", 4'b0000, 0, 0, 1, 0);
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000);
    check("after_release", 4'b0000, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel);
      check(vecs[i].name, vecs[i].g, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
    end

    // Outputs must hold between edges when inputs change.
    apply(1'b0, 4'b0001, 4'b0010, 4'b0010);
    check("stream_1p2", 4'b0011, 0, 0, 0, 0);
    A = 4'b1110; G_select = 4'b1110;
    #3;
    check("hold_between_edges", 4'b0011, 0, 0, 0, 0);

    // Mid-stream reset for exactly one edge, then resume with current inputs.
    apply(1'b0, 4'b0100, 4'b0001, 4'b0010);
    check("stream_4p1", 4'b0101, 0, 0, 0, 0);
    apply(1'b1, 4'b0101, 4'b0010, 4'b0010);
    check("mid_reset", 4'b0000, 0, 0, 1, 0);
    apply(1'b0, 4'b0101, 4'b0010, 4'b0010);
    check("resume_5p2", 4'b0111, 0, 0, 0, 0);
    apply(1'b0, 4'b0110, 4'b0011, 4'b0010);
    check("stream_6p3", 4'b1001, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
